// File: rtl/mem_lsu.sv
// Load/store unit: byte/half/word access to a word-addressed memory, with sub-word stores done as read-modify-write.
// Define MEM_LSU_ERR_EN to report misaligned addresses and illegal sizes; undefined, accesses are truncated and always proceed.
module mem_lsu #(
    parameter int unsigned WORDSIZE = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_we,
    input  logic [1:0]          i_req_size,
    input  logic                i_req_unsigned,
    input  logic [31:0]         i_req_addr,
    input  logic [WORDSIZE-1:0] i_req_wdata,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [WORDSIZE-1:0] o_rsp_rdata,
    output logic                o_rsp_err,
    output logic                o_mem_wen,
    output logic [31:0]         o_mem_addr,
    output logic [WORDSIZE-1:0] o_mem_wdata,
    input  logic [WORDSIZE-1:0] i_mem_rdata
);

    localparam int unsigned AW   = 32;
    localparam int unsigned HW   = 16;
    localparam int unsigned BW   = 8;
    localparam logic [1:0]  SZ_B = 2'b00;
    localparam logic [1:0]  SZ_H = 2'b01;
    localparam logic [1:0]  SZ_W = 2'b10;
    localparam logic [1:0]  SZ_X = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_we;
    logic [1:0]          r_size;
    logic                r_uns;
    logic [1:0]          r_lane;
    logic [HW-1:0]       r_wdata;
    logic [AW-1:0]       r_mem_addr;
    logic [WORDSIZE-1:0] r_mem_wdata;
    logic [WORDSIZE-1:0] r_rsp_rdata;
    logic                r_rsp_err;

    logic                w_accept;
    logic [1:0]          w_size;
    logic                w_err;
    logic [BW-1:0]       w_byte;
    logic [HW-1:0]       w_half;
    logic [WORDSIZE-1:0] w_ext;
    logic [WORDSIZE-1:0] w_merge;

    assign w_accept = i_req_valid && (r_state == S_IDLE);

    // Request qualification: legal-size/alignment checking or silent truncation
`ifdef MEM_LSU_ERR_EN
    assign w_size = i_req_size;
    assign w_err  = (i_req_size == SZ_X)
                 || ((i_req_size == SZ_H) && i_req_addr[0])
                 || ((i_req_size == SZ_W) && (i_req_addr[1:0] != 2'b00));
`else
    assign w_size = (i_req_size == SZ_X) ? SZ_W : i_req_size;
    assign w_err  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_state_nxt = S_RESP;
                    end else if (!i_req_we) begin
                        w_state_nxt = S_RD;
                    end else if (w_size == SZ_W) begin
                        w_state_nxt = S_WR;
                    end else begin
                        w_state_nxt = S_RD;
                    end
                end
            end
            S_RD:    w_state_nxt = r_we ? S_WR : S_RESP;
            S_WR:    w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = i_rsp_ready ? S_IDLE : S_RESP;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake and write strobe decoded straight from the state register
    always_comb begin
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        o_mem_wen   = 1'b0;
        case (r_state)
            S_IDLE:  o_req_ready = 1'b1;
            S_WR:    o_mem_wen   = 1'b1;
            S_RESP:  o_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Lane selection of the word currently returned by memory
    always_comb begin
        w_byte = i_mem_rdata[7:0];
        case (r_lane)
            2'd1:    w_byte = i_mem_rdata[15:8];
            2'd2:    w_byte = i_mem_rdata[23:16];
            2'd3:    w_byte = i_mem_rdata[31:24];
            default: w_byte = i_mem_rdata[7:0];
        endcase
        w_half = r_lane[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    end

    // Load extension
    always_comb begin
        w_ext = i_mem_rdata;
        case (r_size)
            SZ_B: w_ext = r_uns ? {{(WORDSIZE-BW){1'b0}}, w_byte}
                                : {{(WORDSIZE-BW){w_byte[BW-1]}}, w_byte};
            SZ_H: w_ext = r_uns ? {{(WORDSIZE-HW){1'b0}}, w_half}
                                : {{(WORDSIZE-HW){w_half[HW-1]}}, w_half};
            default: w_ext = i_mem_rdata;
        endcase
    end

    // Store merge: replace only the target lane of the word read back
    always_comb begin
        w_merge = i_mem_rdata;
        case (r_size)
            SZ_B: begin
                case (r_lane)
                    2'd0:    w_merge[7:0]   = r_wdata[7:0];
                    2'd1:    w_merge[15:8]  = r_wdata[7:0];
                    2'd2:    w_merge[23:16] = r_wdata[7:0];
                    default: w_merge[31:24] = r_wdata[7:0];
                endcase
            end
            SZ_H: begin
                if (r_lane[1]) begin
                    w_merge[31:16] = r_wdata;
                end else begin
                    w_merge[15:0] = r_wdata;
                end
            end
            default: w_merge = i_mem_rdata;
        endcase
    end

    // Request capture, read-data capture and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_size      <= SZ_B;
            r_uns       <= 1'b0;
            r_lane      <= 2'b00;
            r_wdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we        <= i_req_we;
                r_size      <= w_size;
                r_uns       <= i_req_unsigned;
                r_lane      <= i_req_addr[1:0];
                r_wdata     <= i_req_wdata[HW-1:0];
                r_rsp_err   <= w_err;
                r_rsp_rdata <= '0;
                // Errored requests never touch the memory-side registers
                if (!w_err) begin
                    r_mem_addr <= {i_req_addr[AW-1:2], 2'b00};
                    if (i_req_we && (w_size == SZ_W)) begin
                        r_mem_wdata <= i_req_wdata;
                    end
                end
            end else if (r_state == S_RD) begin
                if (r_we) begin
                    r_mem_wdata <= w_merge;
                end else begin
                    r_rsp_rdata <= w_ext;
                end
            end
        end
    end

    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu with a behavioural word memory.
// Error-checking scenarios follow MEM_LSU_ERR_EN, matching the build of the unit.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_lsu #(.WORDSIZE(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_we      (req_we),
        .i_req_size    (req_size),
        .i_req_unsigned(req_unsigned),
        .i_req_addr    (req_addr),
        .i_req_wdata   (req_wdata),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_rdata   (rsp_rdata),
        .o_rsp_err     (rsp_err),
        .o_mem_wen     (mem_wen),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .i_mem_rdata   (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr[9:2]] <= mem_wdata;
    end

    // One complete transaction; lat counts cycles from the accept edge to rsp_valid (99 = timed out)
    task automatic run(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output logic [31:0] rdata, output logic err,
                       output int wen_cnt, output int wen_at, output logic [31:0] wen_addr);
        lat = 99; rdata = '0; err = 1'b0; wen_cnt = 0; wen_at = 0; wen_addr = '0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_we = 1'($urandom);
        for (int c = 1; c <= 10; c++) begin
            if (mem_wen) begin
                wen_cnt++; wen_at = c; wen_addr = mem_addr;
            end
            if (rsp_valid) begin
                lat = c; rdata = rsp_rdata; err = rsp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        #2;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        total++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            bad++; $display("FAIL reset_rsp got v=%b e=%b d=%h exp 0/0/0", rsp_valid, rsp_err, rsp_rdata); end
        total++; if (mem_wen !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            bad++; $display("FAIL reset_mem got wen=%b a=%h d=%h exp 0/0/0", mem_wen, mem_addr, mem_wdata); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL reset_release got rdy=%b v=%b exp 1/0", req_ready, rsp_valid); end
    endtask

    task automatic test_word_store_load;
        int lat, wc, wat; logic [31:0] d, wa; logic e;
        run(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, lat, d, e, wc, wat, wa);
        total++; if (lat != 2) begin bad++; $display("FAIL sw_latency got=%0d exp=2", lat); end
        total++; if (wc != 1 || wat != 1 || wa !== 32'h100) begin
            bad++; $display("FAIL sw_wen got cnt=%0d at=%0d addr=%h exp 1/1/00000100", wc, wat, wa); end
        total++; if (d !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL sw_rsp got d=%h e=%b exp 0/0", d, e); end
        total++; if (mem[8'h40] !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_mem got=%h exp=deadbeef", mem[8'h40]); end
        run(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, d, e, wc, wat, wa);
        total++; if (lat != 2 || wc != 0) begin bad++; $display("FAIL lw_timing got lat=%0d wen=%0d exp 2/0", lat, wc); end
        total++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin bad++; $display("FAIL lw_data got=%h e=%b exp=deadbeef/0", d, e); end
    endtask

    task automatic test_subword_store;
        int lat, wc, wat; logic [31:0] d, wa; logic e;
        run(1'b1, 2'b10, 1'b0, 32'h200, 32'h11223344, lat, d, e, wc, wat, wa);
        run(1'b1, 2'b00, 1'b0, 32'h202, 32'hFFFFFFAA, lat, d, e, wc, wat, wa);
        total++; if (lat != 3 || e !== 1'b0) begin bad++; $display("FAIL sb_latency got lat=%0d e=%b exp 3/0", lat, e); end
        total++; if (wc != 1 || wat != 2) begin bad++; $display("FAIL sb_wen got cnt=%0d at=%0d exp 1/2", wc, wat); end
        total++; if (mem[8'h80] !== 32'h11AA3344) begin bad++; $display("FAIL sb_merge got=%h exp=11aa3344", mem[8'h80]); end
        run(1'b1, 2'b01, 1'b0, 32'h200, 32'h5555BEEF, lat, d, e, wc, wat, wa);
        total++; if (lat != 3) begin bad++; $display("FAIL sh_latency got=%0d exp=3", lat); end
        total++; if (mem[8'h80] !== 32'h11AABEEF) begin bad++; $display("FAIL sh_merge got=%h exp=11aabeef", mem[8'h80]); end
        run(1'b1, 2'b01, 1'b0, 32'h2F2, 32'h0000CAFE, lat, d, e, wc, wat, wa);
        run(1'b0, 2'b10, 1'b0, 32'h2F0, 32'h0, lat, d, e, wc, wat, wa);
        total++; if (d[31:16] !== 16'hCAFE) begin bad++; $display("FAIL sh_upper got=%h exp=cafe", d[31:16]); end
    endtask

    task automatic test_load_ext;
        int lat, wc, wat; logic [31:0] d, wa; logic e;
        logic [31:0] t_addr [10] = '{32'h302, 32'h302, 32'h302, 32'h300, 32'h302,
                                     32'h300, 32'h301, 32'h303, 32'h303, 32'h300};
        logic [1:0]  t_size [10] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01,
                                     2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
        logic        t_uns  [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                                     1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] t_exp  [10] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h00000001, 32'h000080FF,
                                     32'h00007F01, 32'h0000007F, 32'hFFFFFF80, 32'h00000080, 32'h80FF7F01};
        run(1'b1, 2'b10, 1'b0, 32'h300, 32'h80FF7F01, lat, d, e, wc, wat, wa);
        for (int i = 0; i < 10; i++) begin
            run(1'b0, t_size[i], t_uns[i], t_addr[i], 32'h0, lat, d, e, wc, wat, wa);
            total++;
            if (d !== t_exp[i] || lat != 2 || e !== 1'b0) begin
                bad++;
                $display("FAIL load_ext[%0d] addr=%h got d=%h lat=%0d e=%b exp d=%h lat=2 e=0",
                         i, t_addr[i], d, lat, e, t_exp[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] d0;
        int w;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h300; rsp_ready = 1'b0;
        @(negedge clk);
        req_we = 1'b1; req_wdata = 32'h12345678;
        w = 0;
        while (!rsp_valid && w < 10) begin @(negedge clk); w++; end
        d0 = rsp_rdata;
        total++; if (w != 1 || d0 !== 32'h80FF7F01) begin
            bad++; $display("FAIL bp_first got wait=%0d d=%h exp 1/80ff7f01", w, d0); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== d0 || req_ready !== 1'b0 || mem_wen !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d] got v=%b d=%h rdy=%b wen=%b exp 1/%h/0/0",
                         c, rsp_valid, rsp_rdata, req_ready, mem_wen, d0);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem[8'hC0] !== 32'h80FF7F01) begin
            bad++; $display("FAIL bp_release got rdy=%b v=%b mem=%h exp 1/0/80ff7f01", req_ready, rsp_valid, mem[8'hC0]); end
        @(negedge clk);
        req_valid = 1'b0;
        total++; if (mem_wen !== 1'b1 || mem_addr !== 32'h300) begin
            bad++; $display("FAIL bp_second_wr got wen=%b a=%h exp 1/00000300", mem_wen, mem_addr); end
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || mem[8'hC0] !== 32'h12345678) begin
            bad++; $display("FAIL bp_second_rsp got v=%b mem=%h exp 1/12345678", rsp_valid, mem[8'hC0]); end
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h300; req_wdata = 32'h80FF7F01;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_errors;
        int lat, wc, wat; logic [31:0] d, wa; logic e;
`ifdef MEM_LSU_ERR_EN
        run(1'b0, 2'b01, 1'b0, 32'h301, 32'h0, lat, d, e, wc, wat, wa);
        total++; if (lat != 1 || e !== 1'b1 || d !== 32'h0 || wc != 0) begin
            bad++; $display("FAIL err_half_ld got lat=%0d e=%b d=%h wen=%0d exp 1/1/0/0", lat, e, d, wc); end
        run(1'b1, 2'b10, 1'b0, 32'h302, 32'hCAFEBABE, lat, d, e, wc, wat, wa);
        total++; if (lat != 1 || e !== 1'b1 || d !== 32'h0 || wc != 0) begin
            bad++; $display("FAIL err_word_st got lat=%0d e=%b d=%h wen=%0d exp 1/1/0/0", lat, e, d, wc); end
        total++; if (mem[8'hC0] !== 32'h80FF7F01) begin bad++; $display("FAIL err_mem got=%h exp=80ff7f01", mem[8'hC0]); end
        run(1'b0, 2'b11, 1'b0, 32'h300, 32'h0, lat, d, e, wc, wat, wa);
        total++; if (lat != 1 || e !== 1'b1 || d !== 32'h0) begin
            bad++; $display("FAIL err_size got lat=%0d e=%b d=%h exp 1/1/0", lat, e, d); end
        run(1'b1, 2'b01, 1'b0, 32'h303, 32'h0000FFFF, lat, d, e, wc, wat, wa);
        total++; if (e !== 1'b1 || wc != 0 || mem[8'hC0] !== 32'h80FF7F01) begin
            bad++; $display("FAIL err_half_st got e=%b wen=%0d mem=%h exp 1/0/80ff7f01", e, wc, mem[8'hC0]); end
`else
        run(1'b0, 2'b01, 1'b0, 32'h301, 32'h0, lat, d, e, wc, wat, wa);
        total++; if (lat != 2 || e !== 1'b0 || d !== 32'h00007F01) begin
            bad++; $display("FAIL trunc_half_ld got lat=%0d e=%b d=%h exp 2/0/00007f01", lat, e, d); end
        run(1'b1, 2'b10, 1'b0, 32'h302, 32'hCAFEBABE, lat, d, e, wc, wat, wa);
        total++; if (lat != 2 || e !== 1'b0 || wc != 1 || wa !== 32'h300) begin
            bad++; $display("FAIL trunc_word_st got lat=%0d e=%b wen=%0d a=%h exp 2/0/1/00000300", lat, e, wc, wa); end
        total++; if (mem[8'hC0] !== 32'hCAFEBABE) begin bad++; $display("FAIL trunc_mem got=%h exp=cafebabe", mem[8'hC0]); end
        run(1'b0, 2'b11, 1'b1, 32'h303, 32'h0, lat, d, e, wc, wat, wa);
        total++; if (lat != 2 || e !== 1'b0 || d !== 32'hCAFEBABE) begin
            bad++; $display("FAIL trunc_size got lat=%0d e=%b d=%h exp 2/0/cafebabe", lat, e, d); end
`endif
    endtask

    task automatic test_reset_mid;
        int lat, wc, wat; logic [31:0] d, wa; logic e;
        int seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h201; req_wdata = 32'h00000055; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        total++; if (mem_wen !== 1'b0 || mem_addr !== 32'h200) begin
            bad++; $display("FAIL rst_mid_rd got wen=%b a=%h exp 0/00000200", mem_wen, mem_addr); end
        rst_n = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            bad++; $display("FAIL rst_mid_rsp got rdy=%b v=%b e=%b d=%h exp 1/0/0/0", req_ready, rsp_valid, rsp_err, rsp_rdata); end
        total++; if (mem_wen !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            bad++; $display("FAIL rst_mid_mem got wen=%b a=%h d=%h exp 0/0/0", mem_wen, mem_addr, mem_wdata); end
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_wen) seen++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_wen || rsp_valid) seen++;
        end
        total++; if (seen != 0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL rst_mid_after got spurious=%0d rdy=%b exp 0/1", seen, req_ready); end
        total++; if (mem[8'h80] !== 32'h11AABEEF) begin bad++; $display("FAIL rst_mid_unmod got=%h exp=11aabeef", mem[8'h80]); end
        run(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, lat, d, e, wc, wat, wa);
        total++; if (lat != 2 || d !== 32'h11AABEEF || e !== 1'b0) begin
            bad++; $display("FAIL rst_mid_load got lat=%0d d=%h e=%b exp 2/11aabeef/0", lat, d, e); end
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_subword_store();
        test_load_ext();
        test_backpressure();
        test_errors();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
